// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_param
// Description : Parametrised UART transmitter with an internal baud counter
//               and a valid/ready byte interface. The frame is a start bit,
//               DATA_BITS data bits sent LSB first, an optional parity bit
//               and STOP_BITS stop bits. Every bit lasts CLKS_PER_BIT clocks.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//               DATA_BITS     data bits per frame (5..9)
//               PARITY        0 = none, 1 = odd, 2 = even
//               STOP_BITS     stop bits per frame (1 or 2)
// Ports       : clk         system clock
//               rst         synchronous active-high reset
//               tx_data     word to send, sampled only on accept
//               tx_valid    source has a word
//               tx_break    (UART_TX_BREAK_EN only) hold line in break
//               tx_ready    block can accept a word (IDLE only)
//               tx_busy     frame (or break) in progress
//               tx_done     one-cycle pulse at end of frame
//               tx_pin_out  registered serial line, idle/mark = 1
// Options     : define UART_TX_BREAK_EN to add the tx_break input and the
//               break / post-break mark states.
// ============================================================================
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
`ifdef UART_TX_BREAK_EN
    input  logic                 tx_break,
`endif
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_pin_out
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    localparam int              c_CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      c_STOP_LAST = 4'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_DATA     = 3'd2;
    localparam logic [2:0] S_PARITY   = 3'd3;
    localparam logic [2:0] S_STOP     = 3'd4;
`ifdef UART_TX_BREAK_EN
    localparam logic [2:0] S_BREAK    = 3'd5;
    localparam logic [2:0] S_BRK_MARK = 3'd6;
`endif

    logic [2:0]           r_state, w_state_nxt;
    logic [c_CW-1:0]      r_cnt,   w_cnt_nxt;
    logic [3:0]           r_bit,   w_bit_nxt;     // data-bit or stop-bit index
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_par,   w_par_nxt;
    logic                 r_pin,   w_pin_nxt;
    logic                 r_done,  w_done_nxt;
    logic                 w_tick;

    assign w_tick = (r_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_pin   <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_pin   <= w_pin_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The line value is computed for the *next* state
    // so that tx_pin_out comes straight from a flop.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_tick ? '0 : r_cnt + c_CW'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_pin_nxt   = r_pin;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_bit_nxt = '0;
                w_pin_nxt = 1'b1;
`ifdef UART_TX_BREAK_EN
                if (tx_break) begin
                    // Break wins over a pending word in the same cycle.
                    w_state_nxt = S_BREAK;
                    w_pin_nxt   = 1'b0;
                end else
`endif
                if (tx_valid) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = tx_data;
                    // Odd: force the total ones count odd; even: even.
                    w_par_nxt   = (PARITY == 1) ? ~(^tx_data) : (^tx_data);
                    w_pin_nxt   = 1'b0;
                end
            end

            S_START: begin
                w_pin_nxt = 1'b0;
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                    w_pin_nxt   = r_shift[0];
                end
            end

            S_DATA: begin
                w_pin_nxt = r_shift[0];
                if (w_tick) begin
                    if (r_bit == c_DATA_LAST) begin
                        w_bit_nxt = '0;
                        if (PARITY != 0) begin
                            w_state_nxt = S_PARITY;
                            w_pin_nxt   = r_par;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_pin_nxt   = 1'b1;
                        end
                    end else begin
                        w_bit_nxt   = r_bit + 4'd1;
                        w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_pin_nxt   = r_shift[1];
                    end
                end
            end

            S_PARITY: begin
                w_pin_nxt = r_par;
                if (w_tick) begin
                    w_state_nxt = S_STOP;
                    w_bit_nxt   = '0;
                    w_pin_nxt   = 1'b1;
                end
            end

            S_STOP: begin
                w_pin_nxt = 1'b1;
                if (w_tick) begin
                    if (r_bit == c_STOP_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_bit_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit + 4'd1;
                    end
                end
            end

`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                w_cnt_nxt = '0;
                w_pin_nxt = 1'b0;
                if (!tx_break) begin
                    w_state_nxt = S_BRK_MARK;
                    w_pin_nxt   = 1'b1;
                end
            end

            // One bit time of mark so the receiver sees a clean edge
            // before the next start bit.
            S_BRK_MARK: begin
                w_pin_nxt = 1'b1;
                if (w_tick) begin
                    w_state_nxt = S_IDLE;
                end
            end
`endif

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_bit_nxt   = '0;
                w_pin_nxt   = 1'b1;
            end
        endcase
    end

    assign tx_ready   = (r_state == S_IDLE);
    assign tx_busy    = (r_state != S_IDLE);
    assign tx_done    = r_done;
    assign tx_pin_out = r_pin;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_param
// Description : Self-checking bench for uart_tx_param. Four transmitters with
//               different frame formats (8N1, 7E1, 7O1, 8O2) are driven with
//               directed and random words; each frame is compared cycle by
//               cycle against a bit list built from the frame rules.
//               Define UART_TX_BREAK_EN to also exercise the break feature.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_param;

    localparam int c_NU = 4;
    localparam int c_CPB [c_NU] = '{4, 4, 5, 4};
    localparam int c_DB  [c_NU] = '{8, 7, 7, 8};
    localparam int c_PAR [c_NU] = '{0, 2, 1, 1};
    localparam int c_SB  [c_NU] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       r_rst;
    logic [8:0] r_data  [c_NU];
    logic       r_valid [c_NU];
    logic       w_ready [c_NU];
    logic       w_busy  [c_NU];
    logic       w_done  [c_NU];
    logic       w_pin   [c_NU];
`ifdef UART_TX_BREAK_EN
    logic       r_brk   [c_NU];
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < c_NU; g++) begin : g_dut
        uart_tx_param #(
            .CLKS_PER_BIT (c_CPB[g]),
            .DATA_BITS    (c_DB[g]),
            .PARITY       (c_PAR[g]),
            .STOP_BITS    (c_SB[g])
        ) u_dut (
            .clk        (clk),
            .rst        (r_rst),
            .tx_data    (r_data[g][c_DB[g]-1:0]),
            .tx_valid   (r_valid[g]),
`ifdef UART_TX_BREAK_EN
            .tx_break   (r_brk[g]),
`endif
            .tx_ready   (w_ready[g]),
            .tx_busy    (w_busy[g]),
            .tx_done    (w_done[g]),
            .tx_pin_out (w_pin[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge where tx_valid[u]=1 and the unit should be IDLE.
    // Checks the whole frame and returns at the negedge after the tx_done
    // edge. With keep=1, tx_valid stays high and tx_data is switched to nxt
    // right after accept, so the next word follows back-to-back.
    task automatic frame_check(input int u, input bit keep, input logic [8:0] nxt);
        int         c;
        int         n;
        int         ones;
        logic [8:0] w;
        bit         bits[$];
        string      tg;
        c    = c_CPB[u];
        w    = 9'(r_data[u] & 9'((1 << c_DB[u]) - 1));
        ones = $countones(w);
        tg   = $sformatf("u%0d w=%0h", u, w);
        check_eq({tg, " ready_pre"}, 32'(w_ready[u]), 32'd1);
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < c_DB[u]; i++) bits.push_back(w[i]);
        if (c_PAR[u] == 1) bits.push_back((ones % 2) == 0);
        if (c_PAR[u] == 2) bits.push_back((ones % 2) == 1);
        for (int i = 0; i < c_SB[u]; i++) bits.push_back(1'b1);
        n = bits.size() * c;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            if (k == 0) begin
                if (keep) r_data[u] = nxt;
                else      r_valid[u] = 1'b0;
            end
            if (!keep && k == 2 * c) begin
                r_valid[u] = 1'b1;
                r_data[u]  = 9'($urandom);
            end
            if (!keep && k == 3 * c) r_valid[u] = 1'b0;
            check_eq($sformatf("%s pin k=%0d", tg, k), 32'(w_pin[u]), 32'(bits[k / c]));
            if (k % c == 0) begin
                check_eq({tg, " ready_busy"}, 32'(w_ready[u]), 32'd0);
                check_eq({tg, " busy"}, 32'(w_busy[u]), 32'd1);
            end
            if (k % c == 0 || k == n - 1)
                check_eq({tg, " done_early"}, 32'(w_done[u]), 32'd0);
            @(negedge clk);
        end
        check_eq({tg, " done"}, 32'(w_done[u]), 32'd1);
        check_eq({tg, " ready_end"}, 32'(w_ready[u]), 32'd1);
        check_eq({tg, " busy_end"}, 32'(w_busy[u]), 32'd0);
        check_eq({tg, " pin_end"}, 32'(w_pin[u]), 32'd1);
    endtask

    task automatic send(input int u, input logic [8:0] w);
        r_data[u]  = w;
        r_valid[u] = 1'b1;
        frame_check(u, 1'b0, 9'd0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        r_rst = 1'b1;
        for (int u = 0; u < c_NU; u++) begin
            r_data[u]  = '0;
            r_valid[u] = 1'b0;
`ifdef UART_TX_BREAK_EN
            r_brk[u]   = 1'b0;
`endif
        end
        repeat (3) @(negedge clk);
        r_rst = 1'b0;
        for (int u = 0; u < c_NU; u++) begin
            check_eq($sformatf("u%0d rst_pin", u), 32'(w_pin[u]), 32'd1);
            check_eq($sformatf("u%0d rst_ready", u), 32'(w_ready[u]), 32'd1);
            check_eq($sformatf("u%0d rst_busy", u), 32'(w_busy[u]), 32'd0);
            check_eq($sformatf("u%0d rst_done", u), 32'(w_done[u]), 32'd0);
        end
        @(negedge clk);

        // Directed frames
        send(0, 9'h055);
        send(1, 9'h041);
        send(2, 9'h041);
        send(3, 9'h0FF);

        // Back-to-back with tx_valid held high
        r_data[0]  = 9'h0A5;
        r_valid[0] = 1'b1;
        frame_check(0, 1'b1, 9'h03C);
        frame_check(0, 1'b0, 9'd0);
        repeat (2) @(negedge clk);

        // Reset during data bit 3 of an 8N1 frame (0xC3: bit 3 = 0)
        r_data[0]  = 9'h0C3;
        r_valid[0] = 1'b1;
        @(negedge clk);
        r_valid[0] = 1'b0;
        repeat (17) @(negedge clk);
        check_eq("mid_rst pin_before", 32'(w_pin[0]), 32'd0);
        check_eq("mid_rst busy_before", 32'(w_busy[0]), 32'd1);
        r_rst = 1'b1;
        @(negedge clk);
        r_rst = 1'b0;
        check_eq("mid_rst pin", 32'(w_pin[0]), 32'd1);
        check_eq("mid_rst ready", 32'(w_ready[0]), 32'd1);
        check_eq("mid_rst busy", 32'(w_busy[0]), 32'd0);
        check_eq("mid_rst done", 32'(w_done[0]), 32'd0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check_eq("mid_rst quiet_done", 32'(w_done[0]), 32'd0);
            check_eq("mid_rst quiet_pin", 32'(w_pin[0]), 32'd1);
        end
        send(0, 9'h0E7);

        // Random words on every format
        for (int u = 0; u < c_NU; u++) begin
            for (int i = 0; i < 6; i++) send(u, 9'($urandom));
        end

`ifdef UART_TX_BREAK_EN
        // Break for 20 cycles with a word pending; break must win.
        r_brk[0]   = 1'b1;
        r_data[0]  = 9'h05A;
        r_valid[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_eq($sformatf("brk pin k=%0d", k), 32'(w_pin[0]), 32'd0);
            check_eq("brk ready", 32'(w_ready[0]), 32'd0);
            check_eq("brk busy", 32'(w_busy[0]), 32'd1);
        end
        r_brk[0]   = 1'b0;
        r_valid[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq($sformatf("brk mark k=%0d", k), 32'(w_pin[0]), 32'd1);
            check_eq("brk mark ready", 32'(w_ready[0]), 32'd0);
            check_eq("brk mark done", 32'(w_done[0]), 32'd0);
        end
        @(negedge clk);
        check_eq("brk end ready", 32'(w_ready[0]), 32'd1);
        check_eq("brk end done", 32'(w_done[0]), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("brk no_accept pin", 32'(w_pin[0]), 32'd1);
            check_eq("brk no_accept ready", 32'(w_ready[0]), 32'd1);
        end
        send(0, 9'h081);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
